// File: rtl/score_keeper.sv
// Score and session-best tracker with IDLE/PLAY/OVER game FSM, feeding the 7-seg display value.
// All outputs are registered; data trails its selected source by one cycle.
module score_keeper #(
    parameter int unsigned MAX_SCORE      = 999999,
    parameter int unsigned HOLDOFF_CYCLES = 25_000_000
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        game_start,
    input  logic        pass_pipe,
    input  logic        collide,
    output logic [1:0]  game_state,
    output logic [19:0] score,
    output logic [19:0] best,
    output logic        new_best,
    output logic [19:0] data
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2,
        BAD  = 2'd3
    } state_t;

    localparam int          HW       = (HOLDOFF_CYCLES < 1) ? 1 : $clog2(HOLDOFF_CYCLES + 1);
    localparam logic [19:0] MAX_S    = 20'(MAX_SCORE);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLDOFF_CYCLES);

    state_t         state_q;
    logic [19:0]    score_q;
    logic [19:0]    best_q;
    logic           new_best_q;
    logic [19:0]    data_q;
    logic           pass_q;
    logic [HW-1:0]  holdoff_q;

    logic           pass_rise;
    logic [19:0]    score_inc;
    logic [19:0]    score_new;

    assign pass_rise = pass_pipe & ~pass_q;
    assign score_inc = (score_q >= MAX_S) ? MAX_S : score_q + 20'd1;
    // Score the collision against best including any increment from the same cycle.
    assign score_new = pass_rise ? score_inc : score_q;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q    <= IDLE;
            score_q    <= '0;
            best_q     <= '0;
            new_best_q <= 1'b0;
            data_q     <= '0;
            pass_q     <= 1'b0;
            holdoff_q  <= '0;
        end else begin
            pass_q <= pass_pipe;
            data_q <= (state_q == IDLE) ? best_q : score_q;
            case (state_q)
                IDLE: begin
                    if (game_start) begin
                        state_q    <= PLAY;
                        score_q    <= '0;
                        new_best_q <= 1'b0;
                    end
                end
                PLAY: begin
                    if (pass_rise) begin
                        score_q <= score_inc;
                    end
                    if (collide) begin
                        state_q   <= OVER;
                        holdoff_q <= '0;
                        if (score_new > best_q) begin
                            best_q     <= score_new;
                            new_best_q <= 1'b1;
                        end
                    end
                end
                OVER: begin
                    if (holdoff_q != HOLD_MAX) begin
                        holdoff_q <= holdoff_q + HW'(1);
                    end
                    // A start request before the holdoff expires is simply dropped.
                    if (game_start && (holdoff_q == HOLD_MAX)) begin
                        state_q    <= PLAY;
                        score_q    <= '0;
                        new_best_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign game_state = state_q;
    assign score      = score_q;
    assign best       = best_q;
    assign new_best   = new_best_q;
    assign data       = data_q;
endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper with a small MAX_SCORE and HOLDOFF_CYCLES.
module tb_score_keeper;
    logic        clk = 1'b0;
    logic        rst, game_start, pass_pipe, collide;
    logic [1:0]  game_state;
    logic [19:0] score, best, data;
    logic        new_best;
    int          vecs = 0;
    int          miss = 0;

    score_keeper #(.MAX_SCORE(5), .HOLDOFF_CYCLES(16)) dut (
        .sys_clk(clk), .sys_rst(rst), .game_start(game_start),
        .pass_pipe(pass_pipe), .collide(collide), .game_state(game_state),
        .score(score), .best(best), .new_best(new_best), .data(data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        game_start = 1'b1; tick(); game_start = 1'b0;
    endtask

    task automatic rise();
        pass_pipe = 1'b1; tick(); pass_pipe = 1'b0; tick();
    endtask

    task automatic hit();
        collide = 1'b1; tick(); collide = 1'b0;
    endtask

    task automatic restart();
        repeat (20) tick();
        pulse_start();
    endtask

    task automatic test_reset();
        rst = 1'b1; repeat (3) tick(); rst = 1'b0;
        vecs++; if (game_state !== 2'd0) begin miss++; $display("FAIL reset_state got %0d exp 0", game_state); end
        vecs++; if (score !== 20'd0) begin miss++; $display("FAIL reset_score got %0d exp 0", score); end
        vecs++; if (best !== 20'd0) begin miss++; $display("FAIL reset_best got %0d exp 0", best); end
        vecs++; if (new_best !== 1'b0) begin miss++; $display("FAIL reset_new_best got %0d exp 0", new_best); end
        vecs++; if (data !== 20'd0) begin miss++; $display("FAIL reset_data got %0d exp 0", data); end
        hit(); rise();
        vecs++; if (game_state !== 2'd0) begin miss++; $display("FAIL idle_ignore_state got %0d exp 0", game_state); end
        vecs++; if (score !== 20'd0) begin miss++; $display("FAIL idle_ignore_score got %0d exp 0", score); end
        vecs++; if (data !== best) begin miss++; $display("FAIL idle_data_best got %0d exp %0d", data, best); end
    endtask

    task automatic test_count();
        pulse_start();
        vecs++; if (game_state !== 2'd1) begin miss++; $display("FAIL start_state got %0d exp 1", game_state); end
        for (int i = 1; i <= 3; i++) begin
            pass_pipe = 1'b1; tick();
            vecs++; if (score !== 20'(i)) begin miss++; $display("FAIL count_score got %0d exp %0d", score, i); end
            tick();
            vecs++; if (data !== 20'(i)) begin miss++; $display("FAIL count_data got %0d exp %0d", data, i); end
            tick(); tick(); pass_pipe = 1'b0; tick(); tick();
        end
    endtask

    task automatic test_hold_level();
        pass_pipe = 1'b1; repeat (100) tick(); pass_pipe = 1'b0; tick();
        vecs++; if (score !== 20'd4) begin miss++; $display("FAIL level_once got %0d exp 4", score); end
    endtask

    task automatic test_collide();
        hit();
        vecs++; if (game_state !== 2'd2) begin miss++; $display("FAIL collide_state got %0d exp 2", game_state); end
        vecs++; if (best !== 20'd4) begin miss++; $display("FAIL collide_best got %0d exp 4", best); end
        vecs++; if (new_best !== 1'b1) begin miss++; $display("FAIL collide_new_best got %0d exp 1", new_best); end
        vecs++; if (data !== 20'd4) begin miss++; $display("FAIL collide_data got %0d exp 4", data); end
    endtask

    task automatic test_holdoff();
        rise();
        vecs++; if (score !== 20'd4) begin miss++; $display("FAIL over_ignore_pass got %0d exp 4", score); end
        repeat (3) tick();
        pulse_start();
        vecs++; if (game_state !== 2'd2) begin miss++; $display("FAIL holdoff5_state got %0d exp 2", game_state); end
        repeat (9) tick();
        pulse_start();
        vecs++; if (game_state !== 2'd2) begin miss++; $display("FAIL holdoff15_state got %0d exp 2", game_state); end
        pulse_start();
        vecs++; if (game_state !== 2'd1) begin miss++; $display("FAIL holdoff16_state got %0d exp 1", game_state); end
        vecs++; if (score !== 20'd0) begin miss++; $display("FAIL restart_score got %0d exp 0", score); end
        vecs++; if (new_best !== 1'b0) begin miss++; $display("FAIL restart_new_best got %0d exp 0", new_best); end
        vecs++; if (best !== 20'd4) begin miss++; $display("FAIL restart_best got %0d exp 4", best); end
        tick();
        vecs++; if (data !== 20'd0) begin miss++; $display("FAIL restart_data got %0d exp 0", data); end
    endtask

    task automatic test_saturation();
        repeat (7) rise();
        vecs++; if (score !== 20'd5) begin miss++; $display("FAIL sat_score got %0d exp 5", score); end
        hit();
        vecs++; if (best !== 20'd5) begin miss++; $display("FAIL sat_best got %0d exp 5", best); end
        vecs++; if (new_best !== 1'b1) begin miss++; $display("FAIL sat_new_best got %0d exp 1", new_best); end
        restart();
        repeat (5) rise();
        hit();
        vecs++; if (new_best !== 1'b0) begin miss++; $display("FAIL equal_new_best got %0d exp 0", new_best); end
        vecs++; if (best !== 20'd5) begin miss++; $display("FAIL equal_best got %0d exp 5", best); end
    endtask

    task automatic test_back_to_back();
        rst = 1'b1; tick(); rst = 1'b0;
        pulse_start();
        rise(); rise(); hit();
        vecs++; if (best !== 20'd2) begin miss++; $display("FAIL b2b_prep_best got %0d exp 2", best); end
        restart();
        rise(); rise();
        vecs++; if (score !== 20'd2) begin miss++; $display("FAIL b2b_pre_score got %0d exp 2", score); end
        pass_pipe = 1'b1; collide = 1'b1; tick(); pass_pipe = 1'b0; collide = 1'b0;
        vecs++; if (score !== 20'd3) begin miss++; $display("FAIL b2b_score got %0d exp 3", score); end
        vecs++; if (best !== 20'd3) begin miss++; $display("FAIL b2b_best got %0d exp 3", best); end
        vecs++; if (new_best !== 1'b1) begin miss++; $display("FAIL b2b_new_best got %0d exp 1", new_best); end
        vecs++; if (game_state !== 2'd2) begin miss++; $display("FAIL b2b_state got %0d exp 2", game_state); end
        tick();
        vecs++; if (data !== 20'd3) begin miss++; $display("FAIL b2b_data got %0d exp 3", data); end
        restart();
        rise();
        vecs++; if (score !== 20'd1) begin miss++; $display("FAIL midplay_score got %0d exp 1", score); end
        rst = 1'b1; tick(); rst = 1'b0;
        vecs++; if (game_state !== 2'd0) begin miss++; $display("FAIL rst_play_state got %0d exp 0", game_state); end
        vecs++; if (score !== 20'd0) begin miss++; $display("FAIL rst_play_score got %0d exp 0", score); end
        vecs++; if (best !== 20'd0) begin miss++; $display("FAIL rst_play_best got %0d exp 0", best); end
        vecs++; if (new_best !== 1'b0) begin miss++; $display("FAIL rst_play_new_best got %0d exp 0", new_best); end
        vecs++; if (data !== 20'd0) begin miss++; $display("FAIL rst_play_data got %0d exp 0", data); end
    endtask

    initial begin
        rst = 1'b1; game_start = 1'b0; pass_pipe = 1'b0; collide = 1'b0;
        test_reset();
        test_count();
        test_hold_level();
        test_collide();
        test_holdoff();
        test_saturation();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end
endmodule
